// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame sequencer ($4017 frame counter).
// Holds default step counts, write delay, register bit positions and the mode enum.
package apu_pkg;

  localparam int unsigned DEF_STEP1    = 7457;
  localparam int unsigned DEF_STEP2    = 14913;
  localparam int unsigned DEF_STEP3    = 22371;
  localparam int unsigned DEF_STEP4    = 29829;
  localparam int unsigned DEF_STEP5    = 37281;
  localparam int unsigned DEF_WR_DELAY = 3;
  localparam int unsigned DEF_CNT_W    = 16;

  localparam int unsigned MODE_BIT    = 7;
  localparam int unsigned INHIBIT_BIT = 6;

  typedef enum logic {
    FOUR_STEP = 1'b0,
    FIVE_STEP = 1'b1
  } frame_mode_t;

  typedef struct packed {
    logic quarter;
    logic half;
    logic irq_win;
    logic wrap;
  } step_dec_t;

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: CPU-cycle enables -> quarter/half-frame pulses and frame IRQ.
// Pulses are registered (one clk after the CE edge); no backpressure, inputs are strobes.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP1    = DEF_STEP1,
  parameter int unsigned STEP2    = DEF_STEP2,
  parameter int unsigned STEP3    = DEF_STEP3,
  parameter int unsigned STEP4    = DEF_STEP4,
  parameter int unsigned STEP5    = DEF_STEP5,
  parameter int unsigned WR_DELAY = DEF_WR_DELAY,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_ce,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       mode
);

  localparam int unsigned DLY_W = (WR_DELAY < 1) ? 1 : $clog2(WR_DELAY + 1);

  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_S1      = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] C_S2      = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] C_S3      = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] C_S4      = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] C_S5      = CNT_W'(STEP5);
  localparam logic [CNT_W-1:0] C_S4_PRE  = CNT_W'(STEP4 - 1);
  localparam logic [CNT_W-1:0] C_S4_WRAP = CNT_W'(STEP4 + 1);
  localparam logic [CNT_W-1:0] C_S5_WRAP = CNT_W'(STEP5 + 1);

  localparam logic [DLY_W-1:0] C_DLY_INIT = DLY_W'(WR_DELAY);
  localparam logic [DLY_W-1:0] C_DLY_ONE  = DLY_W'(1);

  if ((longint'(STEP5) + 64'sd1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("apu_frame_sequencer: CNT_W too narrow to hold STEP5+1");
  end

  if (WR_DELAY < 1) begin : g_wr_delay_check
    $error("apu_frame_sequencer: WR_DELAY must be at least 1");
  end

  // Step table for the current mode; the IRQ window only exists in 4-step mode.
  function automatic step_dec_t step_decode(input logic [CNT_W-1:0] c, input frame_mode_t m);
    step_dec_t d;
    d = '0;
    if (m == FOUR_STEP) begin
      d.quarter = (c == C_S1) || (c == C_S2) || (c == C_S3) || (c == C_S4);
      d.half    = (c == C_S2) || (c == C_S4);
      d.irq_win = (c == C_S4_PRE) || (c == C_S4) || (c == C_S4_WRAP);
      d.wrap    = (c == C_S4_WRAP);
    end else begin
      d.quarter = (c == C_S1) || (c == C_S2) || (c == C_S3) || (c == C_S5);
      d.half    = (c == C_S2) || (c == C_S5);
      d.irq_win = 1'b0;
      d.wrap    = (c == C_S5_WRAP);
    end
    return d;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  frame_mode_t      r_mode;
  logic             r_inhibit;
  logic             r_irq;
  logic             r_qf;
  logic             r_hf;
  logic             r_pend;
  frame_mode_t      r_pmode;
  logic [DLY_W-1:0] r_delay;

  logic [CNT_W-1:0] w_cnt_next;
  step_dec_t        w_dec;
  logic             w_seq_reset;
  logic             w_irq_set;
  logic             w_irq_wr_clr;
  logic             w_unused_wr_data;

  always_comb begin
    w_cnt_next   = r_cnt + C_ONE;
    w_dec        = step_decode(w_cnt_next, r_mode);
    // A fresh write restarts the delay, so it can never expire on the same edge.
    w_seq_reset  = cpu_ce && !wr_en && r_pend && (r_delay == C_DLY_ONE);
    w_irq_set    = cpu_ce && !w_seq_reset && !r_inhibit && w_dec.irq_win;
    w_irq_wr_clr = wr_en && wr_data[INHIBIT_BIT];
  end

  assign w_unused_wr_data = ^wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inhibit <= 1'b0;
      r_pend    <= 1'b0;
      r_pmode   <= FOUR_STEP;
      r_delay   <= '0;
    end else if (wr_en) begin
      r_inhibit <= wr_data[INHIBIT_BIT];
      r_pend    <= 1'b1;
      r_pmode   <= frame_mode_t'(wr_data[MODE_BIT]);
      r_delay   <= C_DLY_INIT;
    end else if (r_pend && cpu_ce) begin
      r_delay <= r_delay - C_DLY_ONE;
      if (w_seq_reset) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_mode <= FOUR_STEP;
      r_qf   <= 1'b0;
      r_hf   <= 1'b0;
    end else if (w_seq_reset) begin
      r_cnt  <= '0;
      r_mode <= r_pmode;
      r_qf   <= (r_pmode == FIVE_STEP);
      r_hf   <= (r_pmode == FIVE_STEP);
    end else if (cpu_ce) begin
      r_cnt <= w_dec.wrap ? '0 : w_cnt_next;
      r_qf  <= w_dec.quarter;
      r_hf  <= w_dec.half;
    end else begin
      r_qf <= 1'b0;
      r_hf <= 1'b0;
    end
  end

  // Inhibit-write clear beats a set, which beats an acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (w_irq_wr_clr) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign quarter_frame = r_qf;
  assign half_frame    = r_hf;
  assign frame_irq     = r_irq;
  assign mode          = r_mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench: a default-parameter instance runs one full 4-step sequence; a scaled-step instance
// covers mode switches, write delay, IRQ rules and async reset with randomized CE gaps.
module tb_apu_frame_sequencer;

  localparam int WR_DELAY = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ce;
  logic [1:0]      wr;
  logic [1:0]      ack;
  logic [1:0][7:0] wd;
  wire  [1:0]      qf;
  wire  [1:0]      hf;
  wire  [1:0]      irq;
  wire  [1:0]      md;

  always #5 clk = ~clk;

  apu_frame_sequencer u_big (
    .clk(clk), .rst_n(rst_n), .cpu_ce(ce[0]), .wr_en(wr[0]), .wr_data(wd[0]),
    .irq_ack(ack[0]), .quarter_frame(qf[0]), .half_frame(hf[0]),
    .frame_irq(irq[0]), .mode(md[0])
  );

  apu_frame_sequencer #(
    .STEP1(37), .STEP2(73), .STEP3(111), .STEP4(149), .STEP5(187),
    .WR_DELAY(WR_DELAY), .CNT_W(16)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .cpu_ce(ce[1]), .wr_en(wr[1]), .wr_data(wd[1]),
    .irq_ack(ack[1]), .quarter_frame(qf[1]), .half_frame(hf[1]),
    .frame_irq(irq[1]), .mode(md[1])
  );

  // Reference model: position within the sequence plus the step lists per instance.
  int S [2][5];
  int m_pos [2];
  int m_left [2];
  bit m_mode [2];
  bit m_inh [2];
  bit m_irq [2];
  bit m_pend [2];
  bit m_pmode [2];
  bit m_q [2];
  bit m_h [2];

  int n_tests = 0;
  int n_fail  = 0;
  int g_q[$];
  int g_h[$];
  int g_irq_first;
  bit g_irq_any;

  task automatic cmp_bit(input string tag, input int d, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d @%0t: observed %b expected %b", tag, d, $time, obs, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic chk(input int d);
    cmp_bit("quarter_frame", d, qf[d], m_q[d]);
    cmp_bit("half_frame", d, hf[d], m_h[d]);
    cmp_bit("frame_irq", d, irq[d], m_irq[d]);
    cmp_bit("mode", d, md[d], m_mode[d]);
  endtask

  task automatic advance(input int d, output bit set_irq);
    int last;
    last = m_mode[d] ? S[d][4] : S[d][3];
    m_pos[d]++;
    m_q[d] = (m_pos[d] == S[d][0]) || (m_pos[d] == S[d][1]) ||
             (m_pos[d] == S[d][2]) || (m_pos[d] == last);
    m_h[d] = (m_pos[d] == S[d][1]) || (m_pos[d] == last);
    set_irq = !m_mode[d] && !m_inh[d] && (m_pos[d] >= S[d][3] - 1) && (m_pos[d] <= S[d][3] + 1);
    if (m_pos[d] == last + 1) m_pos[d] = 0;
  endtask

  task automatic model_edge(input int d, input bit c, input bit w, input logic [7:0] data,
                            input bit a);
    bit s;
    s = 1'b0;
    m_q[d] = 1'b0;
    m_h[d] = 1'b0;
    if (w) begin
      if (c) advance(d, s);
      m_pend[d]  = 1'b1;
      m_pmode[d] = data[7];
      m_left[d]  = WR_DELAY;
    end else if (c && m_pend[d]) begin
      m_left[d]--;
      if (m_left[d] == 0) begin
        m_pend[d] = 1'b0;
        m_mode[d] = m_pmode[d];
        m_pos[d]  = 0;
        m_q[d]    = m_mode[d];
        m_h[d]    = m_mode[d];
      end else begin
        advance(d, s);
      end
    end else if (c) begin
      advance(d, s);
    end
    if (a) m_irq[d] = 1'b0;
    if (s) m_irq[d] = 1'b1;
    if (w) begin
      m_inh[d] = data[6];
      if (data[6]) m_irq[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_left[k] = 0; m_mode[k] = 0; m_inh[k] = 0; m_irq[k] = 0;
      m_pend[k] = 0; m_pmode[k] = 0; m_q[k] = 0; m_h[k] = 0;
    end
  endtask

  task automatic tick(input int d, input bit c, input bit w, input logic [7:0] data, input bit a);
    ce = '0; wr = '0; ack = '0; wd = '0;
    ce[d] = c; wr[d] = w; ack[d] = a; wd[d] = data;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, ce[k], wr[k], wd[k], ack[k]);
    #1;
    ce = '0; wr = '0; ack = '0; wd = '0;
    chk(0);
    chk(1);
  endtask

  // One CE; the scaled instance gets a random idle gap first.
  task automatic one_ce(input int d, input bit rnd_ack);
    if (d == 1) begin
      repeat ($urandom_range(2, 0)) tick(d, 1'b0, 1'b0, 8'h00, rnd_ack && ($urandom_range(7, 0) == 0));
    end
    tick(d, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_ces(input int d, input int n, input bit rnd_ack);
    g_q.delete();
    g_h.delete();
    g_irq_first = -1;
    g_irq_any   = 1'b0;
    for (int i = 1; i <= n; i++) begin
      one_ce(d, rnd_ack);
      if (qf[d]) g_q.push_back(i);
      if (hf[d]) g_h.push_back(i);
      if (irq[d]) begin
        g_irq_any = 1'b1;
        if (g_irq_first < 0) g_irq_first = i;
      end
    end
  endtask

  task automatic run_until_quarter(input int d, input int max_ce, output int n);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int i = 1; i <= max_ce && !seen; i++) begin
      one_ce(d, 1'b0);
      if (qf[d]) begin
        seen = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic chk_steps(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int h0, input int h1);
    cmp_int({tag, "_q_count"}, g_q.size(), 4);
    cmp_int({tag, "_q0"}, g_q[0], e0);
    cmp_int({tag, "_q1"}, g_q[1], e1);
    cmp_int({tag, "_q2"}, g_q[2], e2);
    cmp_int({tag, "_q3"}, g_q[3], e3);
    cmp_int({tag, "_h_count"}, g_h.size(), 2);
    cmp_int({tag, "_h0"}, g_h[0], h0);
    cmp_int({tag, "_h1"}, g_h[1], h1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_bit({tag, "_q"}, 1, qf[1], 1'b0);
    cmp_bit({tag, "_h"}, 1, hf[1], 1'b0);
    cmp_bit({tag, "_irq_big"}, 0, irq[0], 1'b0);
    chk(0);
    chk(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] r8;
    S[0] = '{7457, 14913, 22371, 29829, 37281};
    S[1] = '{37, 73, 111, 149, 187};
    model_reset();
    rst_n = 1'b0;
    ce = '0; wr = '0; ack = '0; wd = '0;
    #2;
    chk(0);
    chk(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-size 4-step sequence with CE held high every clock.
    run_ces(0, 29830, 1'b0);
    chk_steps("big_4step", 7457, 14913, 22371, 29829, 14913, 29829);
    cmp_int("big_irq_first", g_irq_first, 29828);
    run_until_quarter(0, 8000, n);
    cmp_int("big_wrap_first_quarter", n, 7457);

    // Scaled instance: 4-step sequence and IRQ window.
    run_ces(1, 150, 1'b0);
    chk_steps("t1_4step", 37, 73, 111, 149, 73, 149);
    cmp_int("t1_irq_first", g_irq_first, 148);

    tick(1, 1'b0, 1'b0, 8'h00, 1'b1);
    cmp_bit("t2_ack_clears", 1, irq[1], 1'b0);
    run_ces(1, 150, 1'b0);
    cmp_int("t2_irq_again", g_irq_first, 148);

    // Switch to 5-step.
    tick(1, 1'b0, 1'b0, 8'h00, 1'b1);
    r8 = 8'h80 | 8'($urandom_range(63, 0));
    tick(1, 1'b0, 1'b1, r8, 1'b0);
    one_ce(1, 1'b0);
    one_ce(1, 1'b0);
    cmp_bit("t3_mode_held", 1, md[1], 1'b0);
    one_ce(1, 1'b0);
    cmp_bit("t3_reset_quarter", 1, qf[1], 1'b1);
    cmp_bit("t3_reset_half", 1, hf[1], 1'b1);
    cmp_bit("t3_mode_5step", 1, md[1], 1'b1);
    run_ces(1, 188, 1'b0);
    chk_steps("t3_5step", 37, 73, 111, 187, 73, 187);
    cmp_int("t3_no_irq", int'(g_irq_any), 0);
    run_until_quarter(1, 300, n);
    cmp_int("t3_wrap_first_quarter", n, 37);

    // Back to 4-step, let IRQ rise, then clear it with an inhibit write.
    r8 = 8'($urandom_range(63, 0));
    tick(1, 1'b0, 1'b1, r8, 1'b0);
    repeat (3) one_ce(1, 1'b0);
    cmp_bit("t4_mode_4step", 1, md[1], 1'b0);
    cmp_bit("t4_no_reset_pulse", 1, qf[1], 1'b0);
    run_ces(1, 148, 1'b0);
    cmp_int("t4_irq_first", g_irq_first, 148);
    r8 = 8'h40 | 8'($urandom_range(63, 0));
    tick(1, 1'b0, 1'b1, r8, 1'b0);
    cmp_bit("t4_inhibit_clears", 1, irq[1], 1'b0);
    repeat (3) one_ce(1, 1'b0);
    run_ces(1, 150, 1'b1);
    cmp_int("t4_inhibited_no_irq", int'(g_irq_any), 0);
    chk_steps("t4_4step", 37, 73, 111, 149, 73, 149);

    // Last write wins.
    tick(1, 1'b0, 1'b1, 8'h80, 1'b0);
    one_ce(1, 1'b0);
    tick(1, 1'b0, 1'b1, 8'h00, 1'b0);
    one_ce(1, 1'b0);
    one_ce(1, 1'b0);
    one_ce(1, 1'b0);
    cmp_bit("t5_mode_4step", 1, md[1], 1'b0);
    cmp_bit("t5_no_quarter", 1, qf[1], 1'b0);
    cmp_bit("t5_no_half", 1, hf[1], 1'b0);
    run_until_quarter(1, 300, n);
    cmp_int("t5_first_quarter", n, 37);

    // Async reset with a write pending, just before step 2.
    run_ces(1, 34, 1'b0);
    tick(1, 1'b1, 1'b1, 8'h80, 1'b0);
    do_reset("t6_pending");
    run_until_quarter(1, 300, n);
    cmp_int("t6_first_quarter", n, 37);
    cmp_bit("t6_mode_4step", 1, md[1], 1'b0);
    do_reset("t6_pulse_drop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
